btn_debounce_pulse: RTL
=======================

Name: btn_debounce_pulse

Overview:
- Conditions the raw btnC pad signal into a clean, clocked write strobe for the 4-entry byte store. The store's select demux routes that strobe to one byte latch.
- Synchronizes the pad to clk, rejects contact bounce, and produces a debounced level plus one-cycle press and release pulses.
- Sits between the button pad and the strobe demux, so each physical press causes exactly one write.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, number of consecutive stable synchronized samples needed to accept a transition (10 ms at 100 MHz); must be >= 2.
- REPEAT_DELAY_CYCLES, 50_000_000, cycles held before the first auto-repeat pulse; used only with BTN_REPEAT_EN.
- REPEAT_RATE_CYCLES, 10_000_000, cycles between subsequent auto-repeat pulses; used only with BTN_REPEAT_EN.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_raw  input  1  asynchronous, bouncy pad input.
- btn_level  output  1  debounced button state.
- press_pulse  output  1  one-cycle strobe on an accepted press (and on repeats, when enabled).
- release_pulse  output  1  one-cycle strobe on an accepted release.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on the reset port. No asynchronous reset anywhere.
- Reset values: both synchronizer flops = 0, state = IDLE, counters = 0, btn_level = 0, press_pulse = 0, release_pulse = 0.
- All outputs are registered.
- Synchronizer: a 2-flop chain produces btn_sync. The FSM observes only btn_sync.
- Counter width is $clog2(max of the three cycle parameters)+1. The counter is unsigned and clears on every state change.
- FSM states:
  - IDLE: if btn_sync=1, go to PRESS_WAIT with cnt=0.
  - PRESS_WAIT:
    - btn_sync=0 -> IDLE (bounce rejected, no pulse).
    - btn_sync=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD; btn_level<=1; press_pulse<=1 for one cycle.
    - otherwise cnt++.
  - HELD: if btn_sync=0, go to RELEASE_WAIT with cnt=0.
  - RELEASE_WAIT:
    - btn_sync=1 -> HELD (bounce rejected, btn_level stays 1, no pulse).
    - btn_sync=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE; btn_level<=0; release_pulse<=1 for one cycle.
    - otherwise cnt++.
- Latency: with btn_raw stable high before edge k, press_pulse is high in the cycle after edge k+DEBOUNCE_CYCLES+2. Release latency is the same.
- press_pulse and release_pulse are never high in the same cycle. Every pulse lasts exactly one cycle.
- Reset mid-debounce or while HELD: return to reset values on the next edge; no pulses are emitted.
  - If the button is still held after reset deasserts, the press is re-debounced from IDLE and press_pulse fires once.
- Counter never wraps: it is bounded by the compare and cleared on every transition.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- With the macro defined, in HELD a repeat counter runs:
  - After REPEAT_DELAY_CYCLES in HELD, press_pulse fires for one cycle.
  - Thereafter press_pulse fires every REPEAT_RATE_CYCLES while still HELD.
  - Leaving HELD (including entering RELEASE_WAIT) clears the repeat counter.
  - A bounce back into HELD restarts the repeat delay from zero.
- Without the macro: exactly one press_pulse per accepted press. The repeat parameters are ignored, and no repeat logic is synthesized.

Decomposition:
- Shared package btn_pkg holds:
  - typedef enum btn_state_t {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}, 2-bit binary encoding.
  - Default constants for DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES and REPEAT_RATE_CYCLES.
- One sub-module, sync_2ff: a 2-flop synchronizer with synchronous active-high reset to 0. It is reused later for switch inputs.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
- Reset and idle: hold reset 3 cycles with btn_raw=0, then run 20 cycles -> all outputs 0 throughout.
- Clean press: btn_raw 0->1 before edge 0 and held -> press_pulse=1 only in the cycle after edge 6; btn_level=1 from then on; release_pulse stays 0.
- Bounce rejection: btn_raw high for 3 cycles, low for 2, then high steady -> no pulse during the glitch; exactly one press_pulse, 6 edges after the final rising edge.
- Release with bounce: from HELD, btn_raw low 2 cycles, high 1, then low steady -> btn_level stays 1 through the glitch; release_pulse appears once, 6 edges after the last falling edge; btn_level then goes 0.
- Reset mid-operation: assert reset during PRESS_WAIT (cnt=2) with btn_raw still high, deassert after 1 cycle -> no pulse during or at reset; one press_pulse 6 edges after reset deassertion.
- BTN_REPEAT_EN with REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=5: hold the button 30 cycles past the press -> press_pulses at the press, +10, +15, +20, +25, +30. Without the macro -> only the initial pulse.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the button conditioning path.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES     = 1_000_000;
  localparam int unsigned DEF_REPEAT_DELAY_CYCLES = 50_000_000;
  localparam int unsigned DEF_REPEAT_RATE_CYCLES  = 10_000_000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pad inputs, synchronous active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so both stages sample old values.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Debounces the btnC pad into a level plus one-cycle press/release strobes.
// Optional auto-repeat of press_pulse while held is enabled with `define BTN_REPEAT_EN.
module btn_debounce_pulse
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned CNT_W =
    $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_sync;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_level_q, btn_level_d;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic             press_accept;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (btn_sync)
  );

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d         = state_q;
    cnt_d           = cnt_q;
    btn_level_d     = btn_level_q;
    press_accept    = 1'b0;
    release_pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d      = HELD;
          cnt_d        = '0;
          btn_level_d  = 1'b1;
          press_accept = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d         = IDLE;
          cnt_d           = '0;
          btn_level_d     = 1'b0;
          release_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_CYCLES - 1);

  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_armed_q, rpt_armed_d;
  logic             rpt_fire;

  // Runs only while staying in HELD; any exit or re-entry restarts the initial delay.
  always_comb begin
    rpt_cnt_d   = '0;
    rpt_armed_d = 1'b0;
    rpt_fire    = 1'b0;
    if (state_q == HELD && state_d == HELD) begin
      if (rpt_cnt_q == (rpt_armed_q ? RATE_LAST : DELAY_LAST)) begin
        rpt_fire    = 1'b1;
        rpt_armed_d = 1'b1;
      end else begin
        rpt_cnt_d   = rpt_cnt_q + CNT_W'(1);
        rpt_armed_d = rpt_armed_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end

  assign press_pulse_d = press_accept | rpt_fire;
`else
  assign press_pulse_d = press_accept;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      btn_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      btn_level_q     <= btn_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
    end
  end

  assign btn_level     = btn_level_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;

endmodule
